// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and the link mode constants
// common to the master and the FPGA slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_c_o is high on the last of every
// HALF_DIV cycles; restart_i zeroes the count on the next edge.
module spi_clk_div #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  output logic tick_c_o
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_c_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: shifts one WIDTH-bit word out on mosi (LSB first)
// under an active-low chip select while capturing a word from miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HALF_DIV = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             csel
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             csel_q, csel_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tick_c;
  logic             restart_c;

  // Divider restarts whenever the state changes and is held while idle.
  assign restart_c = (state_d != state_q) || (state_q == IDLE);

  spi_clk_div #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rstn      (rstn),
    .restart_i (restart_c),
    .tick_c_o  (tick_c)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    csel_d     = csel_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          tx_sh_d   = tx_data;
          bit_cnt_d = '0;
          csel_d    = 1'b0;
          mosi_d    = tx_data[0];
          state_d   = SETUP;
        end
      end
      SETUP, LOW: begin
        if (tick_c) begin
          sclk_d             = ~CPOL;
          rx_sh_d[bit_cnt_q] = miso;
          state_d            = HIGH;
        end
      end
      HIGH: begin
        if (tick_c) begin
          sclk_d = CPOL;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            // Next bit goes out with the falling edge so it settles before the rise.
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_sh_d   = tx_sh_q >> 1;
            mosi_d    = tx_sh_q[1];
            state_d   = LOW;
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          csel_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= CPOL;
      csel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      csel_q     <= csel_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign csel     = csel_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/H=2 instance (loopback or slave
// model) and a 4-bit/H=3 instance talking to a slave model.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] tx8, rx8;
  logic       v8, r8, rv8, sclk8, mosi8, miso8, csel8;
  logic [3:0] tx4, rx4;
  logic       v4, r4, rv4, sclk4, mosi4, miso4, csel4;

  spi_master #(.WIDTH(8), .HALF_DIV(2)) dut8 (
    .clk(clk), .rstn(rstn), .tx_data(tx8), .tx_valid(v8), .tx_ready(r8),
    .rx_data(rx8), .rx_valid(rv8), .sclk(sclk8), .mosi(mosi8), .miso(miso8),
    .csel(csel8)
  );

  spi_master #(.WIDTH(4), .HALF_DIV(3)) dut4 (
    .clk(clk), .rstn(rstn), .tx_data(tx4), .tx_valid(v4), .tx_ready(r4),
    .rx_data(rx4), .rx_valid(rv4), .sclk(sclk4), .mosi(mosi4), .miso(miso4),
    .csel(csel4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode-0 slave models: launch on falling sclk, capture on rising sclk.
  logic       loop8;
  logic [7:0] s8_tx, s8_rx;
  logic       s8_miso;
  int         s8_idx, s8_edges;
  logic [3:0] s4_tx, s4_rx;
  logic       s4_miso;
  int         s4_idx;

  assign miso8 = loop8 ? mosi8 : s8_miso;
  assign miso4 = s4_miso;

  always @(negedge csel8) begin s8_idx = 0; s8_miso = s8_tx[0]; end
  always @(posedge sclk8) if (!csel8 && s8_idx < 8) begin s8_rx[s8_idx] = mosi8; s8_edges++; end
  always @(negedge sclk8) if (!csel8) begin s8_idx++; if (s8_idx < 8) s8_miso = s8_tx[s8_idx]; end

  always @(negedge csel4) begin s4_idx = 0; s4_miso = s4_tx[0]; end
  always @(posedge sclk4) if (!csel4 && s4_idx < 4) s4_rx[s4_idx] = mosi4;
  always @(negedge sclk4) if (!csel4) begin s4_idx++; if (s4_idx < 4) s4_miso = s4_tx[s4_idx]; end

  // Observation mux so one monitor serves both instances.
  logic       sel;
  logic       m_sclk, m_csel, m_rdy, m_rv, m_mosi;
  logic [7:0] m_rx;
  assign m_sclk = sel ? sclk4 : sclk8;
  assign m_csel = sel ? csel4 : csel8;
  assign m_rdy  = sel ? r4 : r8;
  assign m_rv   = sel ? rv4 : rv8;
  assign m_mosi = sel ? mosi4 : mosi8;
  assign m_rx   = sel ? {4'b0, rx4} : rx8;

  int         q_rv[$], q_csr[$], q_csf[$], q_rdyr[$], q_rdyf[$], q_rise[$];
  logic [7:0] q_rxd[$];
  logic [7:0] mo_word;
  int         n_rise_cs;

  // Accept d0 (cycle 0), then log events for cycles 1..ncyc; with two=1
  // tx_valid stays high so d1 is taken at the next IDLE.
  task automatic xfer(input bit s, input logic [7:0] d0, input bit two,
                      input logic [7:0] d1, input int ncyc);
    logic ps, pc, pr;
    sel = s;
    @(negedge clk);
    if (s) begin tx4 = d0[3:0]; v4 = 1'b1; end
    else   begin tx8 = d0;      v8 = 1'b1; end
    q_rv.delete(); q_rxd.delete(); q_csr.delete(); q_csf.delete();
    q_rdyr.delete(); q_rdyf.delete(); q_rise.delete();
    mo_word = 8'h00; n_rise_cs = 0;
    ps = m_sclk; pc = m_csel; pr = m_rdy;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (two) begin tx8 = d1; tx4 = d1[3:0]; end
        else     begin v8 = 1'b0; v4 = 1'b0; end
      end
      if (c == 38) begin v8 = 1'b0; v4 = 1'b0; end
      if (m_rv) begin q_rv.push_back(c); q_rxd.push_back(m_rx); end
      if (m_csel && !pc) q_csr.push_back(c);
      if (!m_csel && pc) q_csf.push_back(c);
      if (m_rdy && !pr) q_rdyr.push_back(c);
      if (!m_rdy && pr) q_rdyf.push_back(c);
      if (m_sclk && !ps) begin
        q_rise.push_back(c);
        if (!m_csel) begin
          if (n_rise_cs < 8) mo_word[n_rise_cs] = m_mosi;
          n_rise_cs++;
        end
      end
      ps = m_sclk; pc = m_csel; pr = m_rdy;
    end
  endtask

  int rises, pulses;
  logic ps4;

  initial begin
    sel = 1'b0; loop8 = 1'b1;
    v8 = 1'b0; v4 = 1'b0; tx8 = 8'h00; tx4 = 4'h0;
    s8_tx = 8'h00; s8_rx = 8'h00; s8_miso = 1'b0; s8_idx = 0; s8_edges = 0;
    s4_tx = 4'h0; s4_rx = 4'h0; s4_miso = 1'b0; s4_idx = 0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst_sclk", 32'(sclk8), 32'd0);
    check("rst_csel", 32'(csel8), 32'd1);
    check("rst_mosi", 32'(mosi8), 32'd0);
    check("rst_rx_data", 32'(rx8), 32'd0);
    check("rst_rx_valid", 32'(rv8), 32'd0);
    check("rst_tx_ready", 32'(r8), 32'd1);
    check("rst_csel_w4", 32'(csel4), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Loopback 8'h96
    loop8 = 1'b1;
    xfer(1'b0, 8'h96, 1'b0, 8'h00, 40);
    check("t1_rise_count", 32'(q_rise.size()), 32'd8);
    check("t1_first_rise", 32'(q_rise[0]), 32'd3);
    check("t1_sclk_period", 32'(q_rise[1] - q_rise[0]), 32'd4);
    check("t1_mosi_bits", 32'(mo_word), 32'h96);
    check("t1_csel_fall", 32'(q_csf[0]), 32'd1);
    check("t1_csel_rise", 32'(q_csr[0]), 32'd35);
    check("t1_rv_count", 32'(q_rv.size()), 32'd1);
    check("t1_rv_cycle", 32'(q_rv[0]), 32'd35);
    check("t1_rx_data", 32'(q_rxd[0]), 32'h96);
    check("t1_ready_rise", 32'(q_rdyr[0]), 32'd37);
    check("t1_rx_held", 32'(rx8), 32'h96);

    // Slave model returns A5 while master sends 3C
    loop8 = 1'b0; s8_tx = 8'hA5; s8_edges = 0;
    xfer(1'b0, 8'h3C, 1'b0, 8'h00, 40);
    check("t2_rx_data", 32'(q_rxd[0]), 32'hA5);
    check("t2_slave_rx", 32'(s8_rx), 32'h3C);
    check("t2_slave_edges", 32'(s8_edges), 32'd8);
    check("t2_rise_in_csel", 32'(n_rise_cs), 32'd8);

    // Back-to-back 01 then 80 with tx_valid held
    loop8 = 1'b1;
    xfer(1'b0, 8'h01, 1'b1, 8'h80, 80);
    check("t3_rv_count", 32'(q_rv.size()), 32'd2);
    check("t3_rv0_cycle", 32'(q_rv[0]), 32'd35);
    check("t3_rv1_cycle", 32'(q_rv[1]), 32'd72);
    check("t3_rx0", 32'(q_rxd[0]), 32'h01);
    check("t3_rx1", 32'(q_rxd[1]), 32'h80);
    check("t3_csel_gap", 32'(q_csf[1] - q_csr[0]), 32'd3);
    check("t3_ready_fall0", 32'(q_rdyf[0]), 32'd1);
    check("t3_ready_rise0", 32'(q_rdyr[0]), 32'd37);
    check("t3_ready_fall1", 32'(q_rdyf[1]), 32'd38);
    check("t3_ready_rise1", 32'(q_rdyr[1]), 32'd74);

    // Async reset after the 3rd rising edge of an 8'h7E transfer
    loop8 = 1'b1; sel = 1'b0;
    @(negedge clk) begin tx8 = 8'h7E; v8 = 1'b1; end
    @(posedge clk);
    @(negedge clk) v8 = 1'b0;
    rises = 0; ps4 = sclk8;
    for (int c = 0; c < 40 && rises < 3; c++) begin
      @(negedge clk);
      if (sclk8 && !ps4) rises++;
      ps4 = sclk8;
    end
    check("t4_rises_before_rst", 32'(rises), 32'd3);
    check("t4_mosi_before_rst", 32'(mosi8), 32'd1);
    rstn = 1'b0;
    #1;
    check("t4_csel", 32'(csel8), 32'd1);
    check("t4_sclk", 32'(sclk8), 32'd0);
    check("t4_mosi", 32'(mosi8), 32'd0);
    check("t4_tx_ready", 32'(r8), 32'd1);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rv8) pulses++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rv8) pulses++;
    end
    check("t4_no_rx_valid", 32'(pulses), 32'd0);
    check("t4_rx_cleared", 32'(rx8), 32'd0);
    xfer(1'b0, 8'hFF, 1'b0, 8'h00, 40);
    check("t4_next_rv_count", 32'(q_rv.size()), 32'd1);
    check("t4_next_rv_cycle", 32'(q_rv[0]), 32'd35);
    check("t4_next_rx", 32'(q_rxd[0]), 32'hFF);

    // W=4, H=3: send 0111, slave returns 1010
    s4_tx = 4'b1010; s4_rx = 4'h0;
    xfer(1'b1, 8'h07, 1'b0, 8'h00, 35);
    check("t5_rise_count", 32'(q_rise.size()), 32'd4);
    check("t5_first_rise", 32'(q_rise[0]), 32'd4);
    check("t5_sclk_period", 32'(q_rise[1] - q_rise[0]), 32'd6);
    check("t5_mosi_bits", 32'(mo_word), 32'h07);
    check("t5_slave_rx", 32'(s4_rx), 32'h7);
    check("t5_csel_rise", 32'(q_csr[0]), 32'd28);
    check("t5_rv_cycle", 32'(q_rv[0]), 32'd28);
    check("t5_rx_data", 32'(q_rxd[0]), 32'hA);
    check("t5_ready_rise", 32'(q_rdyr[0]), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
